// File: rtl/move_detector.sv
// Chessboard move detector: debounces occupancy snapshots and reports quiet moves and captures.
// Optional capture tracking (LIFT2 state, capture output) is enabled with `define MOVE_DETECTOR_CAPTURE_EN.
module move_detector #(
    parameter int STABLE_SNAPS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] chessLayout,
    input  logic        layout_valid,
    input  logic        resync,
    output logic [5:0]  move_from,
    output logic [5:0]  move_to,
    output logic        capture,
    output logic        move_valid,
    input  logic        move_ready,
    output logic        error
);

    localparam logic [63:0] INIT_BOARD = 64'hFFFF_0000_0000_FFFF;
    localparam int          CW         = $clog2(STABLE_SNAPS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LIFT1,
`ifdef MOVE_DETECTOR_CAPTURE_EN
        LIFT2,
`endif
        REPORT,
        ERROR
    } state_t;

    function automatic logic isOneHot(input logic [63:0] x);
        return (x != '0) && ((x & (x - 64'd1)) == '0);
    endfunction

    function automatic logic [5:0] bitIndex(input logic [63:0] x);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < 64; i++) begin
            if (x[i]) idx = 6'(i);
        end
        return idx;
    endfunction

    state_t        r_state;
    logic [63:0]   r_prevSample;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_stable;
    logic          r_stableEvt;
    logic [63:0]   r_committed;
    logic [63:0]   r_pending;
    logic [5:0]    r_from;
    logic [5:0]    r_to;

    state_t        w_nextState;
    logic [63:0]   w_nextCommitted;
    logic [63:0]   w_nextPending;
    logic [5:0]    w_nextFrom;
    logic [5:0]    w_nextTo;
    logic          w_match;
    logic          w_sat;
    logic [CW-1:0] w_cntNext;
    logic          w_accept;
    logic [63:0]   w_lifted;
    logic [63:0]   w_placed;
    logic [63:0]   w_fromMask;

`ifdef MOVE_DETECTOR_CAPTURE_EN
    logic [5:0]    r_capSq;
    logic          r_capture;
    logic [5:0]    w_nextCapSq;
    logic          w_nextCapture;
    logic [63:0]   w_otherLift;
`endif

    // The counter saturates once a board is accepted, so a held board fires only once.
    assign w_match   = (chessLayout == r_prevSample);
    assign w_sat     = (r_cnt == CW'(STABLE_SNAPS - 1));
    assign w_cntNext = !w_match ? '0 : (w_sat ? r_cnt : r_cnt + 1'b1);
    assign w_accept  = (w_cntNext == CW'(STABLE_SNAPS - 1)) && !(w_match && w_sat);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prevSample <= INIT_BOARD;
            r_cnt        <= '0;
            r_stable     <= INIT_BOARD;
            r_stableEvt  <= 1'b0;
        end else begin
            r_stableEvt <= 1'b0;
            if (layout_valid) begin
                r_prevSample <= chessLayout;
                r_cnt        <= w_cntNext;
                if (w_accept) begin
                    r_stable    <= chessLayout;
                    r_stableEvt <= 1'b1;
                end
            end
        end
    end

    assign w_lifted   = r_committed & ~r_stable;
    assign w_placed   = ~r_committed & r_stable;
    assign w_fromMask = 64'd1 << r_from;
`ifdef MOVE_DETECTOR_CAPTURE_EN
    assign w_otherLift = w_lifted & ~w_fromMask;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_committed <= INIT_BOARD;
            r_pending   <= INIT_BOARD;
            r_from      <= '0;
            r_to        <= '0;
`ifdef MOVE_DETECTOR_CAPTURE_EN
            r_capSq     <= '0;
            r_capture   <= 1'b0;
`endif
        end else begin
            r_state     <= w_nextState;
            r_committed <= w_nextCommitted;
            r_pending   <= w_nextPending;
            r_from      <= w_nextFrom;
            r_to        <= w_nextTo;
`ifdef MOVE_DETECTOR_CAPTURE_EN
            r_capSq     <= w_nextCapSq;
            r_capture   <= w_nextCapture;
`endif
        end
    end

    // Diffs are only acted on when a freshly debounced board arrives; resync overrides everything.
    always_comb begin
        w_nextState     = r_state;
        w_nextCommitted = r_committed;
        w_nextPending   = r_pending;
        w_nextFrom      = r_from;
        w_nextTo        = r_to;
`ifdef MOVE_DETECTOR_CAPTURE_EN
        w_nextCapSq     = r_capSq;
        w_nextCapture   = r_capture;
`endif
        if (resync) begin
            w_nextState     = IDLE;
            w_nextCommitted = r_stable;
        end else begin
            case (r_state)
                IDLE: if (r_stableEvt) begin
                    if (w_lifted == '0 && w_placed == '0) begin
                        w_nextState = IDLE;
                    end else if (isOneHot(w_lifted) && w_placed == '0) begin
                        w_nextState = LIFT1;
                        w_nextFrom  = bitIndex(w_lifted);
                    end else begin
                        w_nextState = ERROR;
                    end
                end
                LIFT1: if (r_stableEvt) begin
                    if (r_stable == r_committed) begin
                        w_nextState = IDLE;
                    end else if (w_lifted == w_fromMask && isOneHot(w_placed)) begin
                        w_nextState   = REPORT;
                        w_nextTo      = bitIndex(w_placed);
                        w_nextPending = r_stable;
`ifdef MOVE_DETECTOR_CAPTURE_EN
                        w_nextCapture = 1'b0;
                    end else if (w_lifted[r_from] && isOneHot(w_otherLift) && w_placed == '0) begin
                        w_nextState = LIFT2;
                        w_nextCapSq = bitIndex(w_otherLift);
`endif
                    end else begin
                        w_nextState = ERROR;
                    end
                end
`ifdef MOVE_DETECTOR_CAPTURE_EN
                LIFT2: if (r_stableEvt) begin
                    if (w_lifted == (w_fromMask | (64'd1 << r_capSq)) && w_placed == '0) begin
                        w_nextState = LIFT2;
                    end else if (w_lifted == w_fromMask && w_placed == '0) begin
                        w_nextState   = REPORT;
                        w_nextTo      = r_capSq;
                        w_nextCapture = 1'b1;
                        w_nextPending = r_stable;
                    end else begin
                        w_nextState = ERROR;
                    end
                end
`endif
                REPORT: if (move_ready) begin
                    w_nextState     = IDLE;
                    w_nextCommitted = r_pending;
                end
                ERROR: if (r_stableEvt && r_stable == r_committed) begin
                    w_nextState = IDLE;
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    assign move_valid = (r_state == REPORT);
    assign error      = (r_state == ERROR);
    assign move_from  = r_from;
    assign move_to    = r_to;
`ifdef MOVE_DETECTOR_CAPTURE_EN
    assign capture    = r_capture;
`else
    assign capture    = 1'b0;
`endif

endmodule
